// File: rtl/noc_leaf_rx_endpoint_if.sv
// Handshake bundle between a NoC leaf_tx port, the receive endpoint and the host core.
// The slave modport is the endpoint's view; the master modport is the view of the NoC and host side.
interface noc_leaf_rx_endpoint_if #(
   parameter int unsigned D_W = 38
);
   logic           noc_vc_target;
   logic [D_W-1:0] noc_data_i;
   logic           noc_vc_credit_gnt;
   logic [D_W-1:0] core_data_o;
   logic           core_valid_o;
   logic           core_ready_i;

   modport slave (
      input  noc_vc_target, noc_data_i, core_ready_i,
      output noc_vc_credit_gnt, core_data_o, core_valid_o
   );

   modport master (
      output noc_vc_target, noc_data_i, core_ready_i,
      input  noc_vc_credit_gnt, core_data_o, core_valid_o
   );
endinterface

// File: rtl/noc_leaf_rx_endpoint.sv
// Core-side receive endpoint for one binary-tree NoC leaf: credit grant, DEPTH-entry flit FIFO,
// valid/ready delivery to the host, and saturating flit/back-pressure counters.
module noc_leaf_rx_endpoint #(
   parameter int unsigned D_W   = 38,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   noc_leaf_rx_endpoint_if.slave    bus,
   output logic [$clog2(DEPTH):0]   fifo_level_o,
   output logic [CNT_W-1:0]         flit_count_o,
   output logic [CNT_W-1:0]         stall_count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [D_W-1:0]   mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] flit_count;
   logic [CNT_W-1:0] stall_count;

   logic gnt;
   logic valid;
   logic push;
   logic pop;
   logic stall;

   // Grant comes from registered occupancy only, so the NoC never sees a path from its own valid.
   always_comb begin
      gnt   = !rst && (level < LW'(DEPTH));
      valid = (level != '0);
      push  = bus.noc_vc_target && gnt;
      pop   = valid && bus.core_ready_i;
      stall = valid && !bus.core_ready_i;
   end

   assign bus.noc_vc_credit_gnt = gnt;
   assign bus.core_valid_o      = valid;
   assign bus.core_data_o       = valid ? mem[rd_ptr] : '0;
   assign fifo_level_o          = level;
   assign flit_count_o          = flit_count;
   assign stall_count_o         = stall_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         flit_count  <= '0;
         stall_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.noc_data_i;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push && (flit_count != '1)) begin
            flit_count <= flit_count + 1'b1;
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end
endmodule
